dac_spi_receiver: RTL
=====================

Name: dac_spi_receiver

Overview:
- Slave-side model and receiver for the PMOD DA3 (AD5541A-style) 16-bit DAC serial link: CS framing, MOSI data, SCLK clock.
- Oversamples the asynchronous SPI pins in the `clock_in` domain and deserialises MSB-first words.
- Commits each correctly sized frame to an input register, then transfers it to a DAC output register under LDAC control.
- Used as the far-end checker for the x/y/r/g/b display DAC channels, and on a second board to recover scan samples.

Parameters:
- WIDTH, 16, bits per SPI frame and width of the data registers.
- ERR_W, 8, width of the saturating frame-error counter.

Ports:
- clock_in  input  1  system clock; must be at least 4x the SCLK frequency.
- reset_in  input  1  synchronous, active-low reset.
- sclk_in  input  1  SPI clock, asynchronous to `clock_in`.
- mosi_in  input  1  SPI data, MSB first, sampled on SCLK rising edge.
- cs_in  input  1  SPI chip select, active low; frames one word.
- ldac_in  input  1  load-DAC strobe, active low (present only with DAC_LDAC_EN).
- data_out  output  WIDTH  input register: last good word.
- dac_out  output  WIDTH  DAC output register: value "driven" to the converter.
- word_valid_out  output  1  one-cycle pulse when `data_out` updates.
- frame_err_out  output  1  one-cycle pulse when a frame is discarded.
- err_count_out  output  ERR_W  saturating count of discarded frames.
- busy_out  output  1  high while a frame is in progress (state SHIFT or COMMIT).

Behaviour:
- Synchronisers:
  - Two-flop synchronisers on `sclk_in`, `mosi_in`, `cs_in` (and `ldac_in`).
  - Reset values: sclk 0, mosi 0, cs 1, ldac 1.
  - A registered previous value of the synced sclk and cs gives edge detection.
- Reset (`reset_in` = 0 at a `clock_in` edge):
  - All outputs go to 0 and state goes to IDLE.
  - Shift register and bit counter clear.
  - The previous-cs register is set to 1.
- State IDLE:
  - A synced cs falling edge moves to SHIFT, clearing the bit counter and shift register.
  - If cs is already low when reset deasserts, nothing is captured until cs returns high and falls again.
- State SHIFT:
  - On each synced sclk rising edge, shift = {shift[WIDTH-2:0], mosi_sync}.
  - Bit counter increments, saturating at WIDTH+1 (counter width $clog2(WIDTH+2)).
  - A synced cs rising edge moves to COMMIT.
  - If an sclk rise and a cs rise are detected in the same cycle, the bit is shifted and counted first, then the FSM enters COMMIT.
- State COMMIT (exactly one cycle), then return to IDLE:
  - If count == WIDTH: `data_out` <= shift and `word_valid_out` pulses in the following cycle.
  - Otherwise (short, long or empty frame): `data_out` is unchanged, `frame_err_out` pulses, and `err_count_out` increments, saturating at all-ones.
  - A cs falling edge during COMMIT is ignored; the cs high time must be at least 2 `clock_in` cycles.
- Latency: `word_valid_out` is high in the 4th `clock_in` cycle after the first edge that samples `cs_in` high.
- SCLK edges while cs is high are ignored.
- Reset mid-frame discards the partial word; no valid or error pulse is generated.
- Pulses never overlap: at most one of `word_valid_out` / `frame_err_out` per frame.

Optional Feature:
- DAC_LDAC_EN defined:
  - The `ldac_in` port exists.
  - While synced ldac is low, `dac_out` <= `data_out` every cycle, tracking `data_out` with 1 cycle of lag.
  - While synced ldac is high, `dac_out` holds.
  - A word committed while ldac is high reaches `dac_out` 1 cycle after the synced ldac goes low.
- DAC_LDAC_EN undefined:
  - No `ldac_in` port (LDAC tied low on the board).
  - `dac_out` updates in the same cycle as `data_out`, i.e. when `word_valid_out` is high.

Test Plan:
- Single frame, 0xA5C3 MSB-first, sclk = `clock_in`/8, cs framing 16 bits -> `data_out` = 0xA5C3; one `word_valid_out` pulse 4 cycles after cs rises; `dac_out` = 0xA5C3 (macro off); `frame_err_out` stays 0.
- Short frame of 15 bits, then long frame of 17 bits -> `data_out` keeps its prior value; two `frame_err_out` pulses; `err_count_out` = 2.
- 300 consecutive 3-bit frames (ERR_W = 8) -> `err_count_out` saturates at 255; a following good frame 0x0001 still gives `data_out` = 0x0001.
- Assert `reset_in` = 0 for 1 cycle after 8 bits of 0xFFFF, with cs held low, then finish the frame -> no pulse; the next full frame 0x1234 is captured correctly.
- DAC_LDAC_EN with ldac held high, send 0x4000 -> `data_out` = 0x4000, `dac_out` = 0; drive ldac low -> `dac_out` = 0x4000 one cycle after the synced ldac falls.
- Back-to-back frames 0x0000, 0xFFFF, 0x8001 with 2-cycle cs high gaps, and sclk toggling while cs is high -> three valid pulses in order; the idle sclk toggles are ignored.

Source files
------------

// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver: slave-side receiver for an AD5541A-style 16-bit DAC link.
// Oversamples asynchronous SCLK/MOSI/CS in the clock_in domain, deserialises
// MSB-first frames, commits correctly sized frames to data_out and counts
// discarded frames with a saturating counter.
// Optional macro DAC_LDAC_EN: adds ldac_in; dac_out then tracks data_out while
// the synchronised LDAC is low and holds while it is high. Without the macro
// dac_out loads together with data_out.
module dac_spi_receiver #(
  parameter int WIDTH = 16,
  parameter int ERR_W = 8
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             sclk_in,
  input  logic             mosi_in,
  input  logic             cs_in,
`ifdef DAC_LDAC_EN
  input  logic             ldac_in,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] dac_out,
  output logic             word_valid_out,
  output logic             frame_err_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic             busy_out
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Synchroniser chains: _p0 first flop, _p1 synced value, _p2 previous synced value
  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1;
  logic cs_p0, cs_p1, cs_p2;
`ifdef DAC_LDAC_EN
  logic ldac_p0, ldac_p1;
`endif

  // sync_fill marks when the chains hold real pin samples rather than reset values;
  // armed is set once CS has genuinely been seen high after reset, so a CS that is
  // already low when reset releases cannot start a frame.
  logic [1:0] sync_fill;
  logic       armed;

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt;

  logic sclk_rise;
  logic cs_rise;
  logic cs_fall;
  logic start_frame;
  logic commit_good;
  logic commit_bad;

  assign sclk_rise   = sclk_p1 & ~sclk_p2;
  assign cs_rise     = cs_p1 & ~cs_p2;
  assign cs_fall     = ~cs_p1 & cs_p2;
  assign start_frame = (state_q == S_IDLE) && cs_fall && armed;

  // Two-flop synchronisers plus previous-value registers for edge detection
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      sclk_p0   <= 1'b0;
      sclk_p1   <= 1'b0;
      sclk_p2   <= 1'b0;
      mosi_p0   <= 1'b0;
      mosi_p1   <= 1'b0;
      cs_p0     <= 1'b1;
      cs_p1     <= 1'b1;
      cs_p2     <= 1'b1;
`ifdef DAC_LDAC_EN
      ldac_p0   <= 1'b1;
      ldac_p1   <= 1'b1;
`endif
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sclk_p0   <= sclk_in;
      sclk_p1   <= sclk_p0;
      sclk_p2   <= sclk_p1;
      mosi_p0   <= mosi_in;
      mosi_p1   <= mosi_p0;
      cs_p0     <= cs_in;
      cs_p1     <= cs_p0;
      cs_p2     <= cs_p1;
`ifdef DAC_LDAC_EN
      ldac_p0   <= ldac_in;
      ldac_p1   <= ldac_p0;
`endif
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & cs_p1);
    end
  end

  // FSM state register
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_frame) state_d = S_SHIFT;
      S_SHIFT:  if (cs_rise) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM output decode: busy flag and commit outcome
  always_comb begin
    busy_out    = 1'b0;
    commit_good = 1'b0;
    commit_bad  = 1'b0;
    case (state_q)
      S_SHIFT:  busy_out = 1'b1;
      S_COMMIT: begin
        busy_out    = 1'b1;
        commit_good = (bit_cnt == CNT_W'(WIDTH));
        commit_bad  = (bit_cnt != CNT_W'(WIDTH));
      end
      default:  busy_out = 1'b0;
    endcase
  end

  // Deserialiser: shift register and saturating bit counter
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (start_frame) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if ((state_q == S_SHIFT) && sclk_rise) begin
      shift_q <= {shift_q[WIDTH-2:0], mosi_p1};
      if (bit_cnt != CNT_W'(WIDTH + 1)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Commit stage: input register, pulses and saturating error counter
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      data_out       <= '0;
      word_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
      err_count_out  <= '0;
    end else begin
      word_valid_out <= commit_good;
      frame_err_out  <= commit_bad;
      if (commit_good) begin
        data_out <= shift_q;
      end
      if (commit_bad && (err_count_out != '1)) begin
        err_count_out <= err_count_out + 1'b1;
      end
    end
  end

  // DAC output register
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      dac_out <= '0;
    end else begin
`ifdef DAC_LDAC_EN
      if (!ldac_p1) begin
        dac_out <= data_out;
      end
`else
      if (commit_good) begin
        dac_out <= shift_q;
      end
`endif
    end
  end

endmodule
